// File: rtl/alu_pkg.sv
// Shared definitions for the ALU logic slice: op encoding, BIST states and the
// reference evaluation used by the self-test sequencer and its benches.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_XNOR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Widest operand the evaluator handles; callers zero-extend and truncate.
   localparam int EVAL_W = 16;

   function automatic logic [EVAL_W-1:0] alu_logic_eval(input op_e op,
                                                        input logic [EVAL_W-1:0] a,
                                                        input logic [EVAL_W-1:0] b);
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

endpackage

// File: rtl/alu_bist_delay.sv
// LAT-stage register pipe aligning the presented vector (and its valid) with
// the UUT result; a plain wire when LAT is 0.
module alu_bist_delay #(
   parameter int DW  = 9,
   parameter int LAT = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   generate
      if (LAT == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign dout = din;
      end else begin : g_pipe
         logic [DW-1:0] pipe_p [LAT];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < LAT; i++) pipe_p[i] <= '0;
            end else begin
               pipe_p[0] <= din;
               for (int i = 1; i < LAT; i++) pipe_p[i] <= pipe_p[i-1];
            end
         end

         assign dout = pipe_p[LAT-1];
      end
   endgenerate

endmodule

// File: rtl/alu_logic_bist.sv
// Self-test sequencer for the ALU bitwise logic units: sweeps every operand
// pair, checks the UUT result, counts mismatches and records the first one.
module alu_logic_bist
   import alu_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int LAT   = 0,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] first_err_a,
   output logic [WIDTH-1:0] first_err_b
);

   localparam int         VW    = 2 * WIDTH;
   localparam logic [1:0] LAT_C = 2'(LAT);

   state_e          state;
   op_e             op_q;
   logic [VW-1:0]   cnt;
   logic [1:0]      drain_cnt;
   logic            first_seen;

   logic            vld_p0;
   logic [VW:0]     vec_pd;
   logic            vld_pd;
   logic [WIDTH-1:0] a_pd, b_pd, exp_y;
   logic            mismatch;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // The vector register drives the UUT directly; a is the upper half.
   assign a      = cnt[VW-1:WIDTH];
   assign b      = cnt[WIDTH-1:0];
   assign vld_p0 = (state == ST_RUN);

   alu_bist_delay #(
      .DW  (VW + 1),
      .LAT (LAT)
   ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ({vld_p0, cnt}),
      .dout (vec_pd)
   );

   // Compare stage: delayed vector lines up with the y it produced.
   assign vld_pd   = vec_pd[VW];
   assign a_pd     = vec_pd[VW-1:WIDTH];
   assign b_pd     = vec_pd[WIDTH-1:0];
   assign exp_y    = WIDTH'(alu_logic_eval(op_q, EVAL_W'(a_pd), EVAL_W'(b_pd)));
   assign mismatch = vld_pd && (y !== exp_y);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         op_q        <= OP_AND;
         cnt         <= '0;
         drain_cnt   <= '0;
         first_seen  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         err_count   <= '0;
         first_err_a <= '0;
         first_err_b <= '0;
      end else begin
         if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (!first_seen) begin
               first_seen  <= 1'b1;
               first_err_a <= a_pd;
               first_err_b <= b_pd;
            end
         end

         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state       <= ST_RUN;
                  op_q        <= op_e'(op);
                  cnt         <= '0;
                  first_seen  <= 1'b0;
                  err_count   <= '0;
                  first_err_a <= '0;
                  first_err_b <= '0;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  pass        <= 1'b0;
               end
            end
            ST_RUN: begin
               if (&cnt) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            // Wait LAT+1 cycles so the last compare has landed before done.
            ST_DRAIN: begin
               if (drain_cnt == LAT_C) begin
                  state <= ST_DONE;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0);
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_logic_bist.sv
// Bench for alu_logic_bist: three instances (LAT 0, LAT 2, narrow counter)
// driven against a configurable UUT and a whole-run reference model.
module tb_alu_logic_bist;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_s [3];
   logic [1:0] op_s    [3];
   logic [3:0] a_s [3], b_s [3], y_s [3], fa_s [3], fb_s [3];
   logic       busy_s [3], done_s [3], pass_s [3];
   logic [7:0] err0, err1;
   logic [3:0] err2;

   logic [1:0] uut_op;
   logic [3:0] fault_mask [256];
   logic       stuck0, invert;
   int         uut_lat;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   alu_logic_bist #(.WIDTH(4), .LAT(0), .ERR_W(8)) dut0 (
      .clk(clk), .rst(rst), .start(start_s[0]), .op(op_s[0]), .a(a_s[0]), .b(b_s[0]),
      .y(y_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
      .err_count(err0), .first_err_a(fa_s[0]), .first_err_b(fb_s[0]));

   alu_logic_bist #(.WIDTH(4), .LAT(2), .ERR_W(8)) dut1 (
      .clk(clk), .rst(rst), .start(start_s[1]), .op(op_s[1]), .a(a_s[1]), .b(b_s[1]),
      .y(y_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
      .err_count(err1), .first_err_a(fa_s[1]), .first_err_b(fb_s[1]));

   alu_logic_bist #(.WIDTH(4), .LAT(0), .ERR_W(4)) dut2 (
      .clk(clk), .rst(rst), .start(start_s[2]), .op(op_s[2]), .a(a_s[2]), .b(b_s[2]),
      .y(y_s[2]), .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
      .err_count(err2), .first_err_a(fa_s[2]), .first_err_b(fb_s[2]));

   // Per-bit truth tables indexed by {a_bit, b_bit}.
   function automatic logic [3:0] ref_logic(input logic [1:0] o, input logic [3:0] x,
                                            input logic [3:0] z);
      logic [3:0] tt;
      logic [3:0] r;
      case (o)
         2'b00:   tt = 4'b1000;
         2'b01:   tt = 4'b1110;
         2'b10:   tt = 4'b0110;
         default: tt = 4'b1001;
      endcase
      for (int i = 0; i < 4; i++) r[i] = tt[{x[i], z[i]}];
      return r;
   endfunction

   // Unit under test, one per DUT, with optional faults and latency.
   for (genvar g = 0; g < 3; g++) begin : g_uut
      logic [3:0] yc, r1, r2;
      always_comb begin
         yc = ref_logic(uut_op, a_s[g], b_s[g]) ^ fault_mask[{a_s[g], b_s[g]}];
         if (stuck0) yc[0] = 1'b0;
         if (invert) yc = ~yc;
      end
      always @(posedge clk) begin
         r1 <= yc;
         r2 <= r1;
      end
      assign y_s[g] = (uut_lat == 0) ? yc : r2;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [7:0] get_err(input int d);
      if (d == 0) return err0;
      if (d == 1) return err1;
      return {4'b0000, err2};
   endfunction

   function automatic int lat_of(input int d);
      return (d == 1) ? 2 : 0;
   endfunction

   task automatic check_zero(input int d);
      chk("zero_a", a_s[d], 0);
      chk("zero_b", b_s[d], 0);
      chk("zero_busy", busy_s[d], 0);
      chk("zero_done", done_s[d], 0);
      chk("zero_pass", pass_s[d], 0);
      chk("zero_err", get_err(d), 0);
      chk("zero_first_a", fa_s[d], 0);
      chk("zero_first_b", fb_s[d], 0);
   endtask

   // Whole-run expectation: sweep all 256 pairs in order with the UUT's behaviour.
   task automatic model_run(input logic [1:0] o, input int errmax, output int errs,
                            output logic [3:0] fa, output logic [3:0] fb);
      logic [3:0] av, bv, got;
      logic       seen;
      errs = 0; fa = 4'h0; fb = 4'h0; seen = 1'b0;
      for (int k = 0; k < 256; k++) begin
         av  = 4'(k / 16);
         bv  = 4'(k % 16);
         got = ref_logic(uut_op, av, bv) ^ fault_mask[k];
         if (stuck0) got[0] = 1'b0;
         if (invert) got = ~got;
         if (got !== ref_logic(o, av, bv)) begin
            if (!seen) begin
               seen = 1'b1; fa = av; fb = bv;
            end
            if (errs < errmax) errs++;
         end
      end
   endtask

   task automatic run_bist(input int d, input logic [1:0] o, input int pulse_at,
                           output int cycles);
      @(negedge clk);
      op_s[d]    = o;
      start_s[d] = 1'b1;
      @(posedge clk);
      #1;
      start_s[d] = 1'b0;
      chk("busy_rise", busy_s[d], 1);
      chk("done_drop", done_s[d], 0);
      cycles = 0;
      while (done_s[d] !== 1'b1 && cycles < 2000) begin
         if (cycles == pulse_at) begin
            start_s[d] = 1'b1;
            op_s[d]    = ~o;
         end else begin
            start_s[d] = 1'b0;
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      start_s[d] = 1'b0;
      chk("busy_fall", busy_s[d], 0);
   endtask

   task automatic run_and_check(input int d, input logic [1:0] o, input int pulse_at);
      int         cyc, errs;
      logic [3:0] fa, fb;
      model_run(o, (d == 2) ? 15 : 255, errs, fa, fb);
      run_bist(d, o, pulse_at, cyc);
      chk("done_cycles", cyc, 257 + lat_of(d));
      chk("err_count", get_err(d), errs);
      chk("pass", pass_s[d], (errs == 0) ? 1 : 0);
      chk("first_err_a", fa_s[d], fa);
      chk("first_err_b", fb_s[d], fb);
      chk("done_a", a_s[d], 0);
      chk("done_b", b_s[d], 0);
   endtask

   initial begin
      int cyc, n;
      for (int d = 0; d < 3; d++) begin
         start_s[d] = 1'b0;
         op_s[d]    = 2'b00;
      end
      for (int k = 0; k < 256; k++) fault_mask[k] = 4'h0;
      uut_op = 2'b11; stuck0 = 1'b0; invert = 1'b0; uut_lat = 0;

      repeat (3) @(posedge clk);
      #1;
      check_zero(0);
      check_zero(2);
      @(negedge clk);
      rst = 1'b0;

      // Correct XNOR unit
      run_and_check(0, 2'b11, -1);

      // Bit 0 stuck at zero under XNOR
      stuck0 = 1'b1;
      run_and_check(0, 2'b11, -1);
      chk("stuck_err_128", err0, 128);
      stuck0 = 1'b0;

      // Registered AND unit with matching latency, then with none programmed
      uut_op  = 2'b00;
      uut_lat = 2;
      run_and_check(1, 2'b00, -1);
      run_bist(0, 2'b00, -1, cyc);
      chk("lat_mismatch_pass", pass_s[0], 0);
      chk("lat_mismatch_err_nz", (err0 != 8'd0) ? 1 : 0, 1);
      uut_lat = 0;

      // Reset mid-run at vector 0x64
      uut_op = 2'b11;
      @(negedge clk);
      op_s[0] = 2'b11; start_s[0] = 1'b1;
      @(posedge clk);
      #1;
      start_s[0] = 1'b0;
      n = 0;
      while (!(a_s[0] == 4'h6 && b_s[0] == 4'h4) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("reached_vec_100", n, 100);
      #2 rst = 1'b1;
      #1;
      check_zero(0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_after_rst_busy", busy_s[0], 0);
      chk("idle_after_rst_a", a_s[0], 0);
      run_and_check(0, 2'b11, -1);

      // start pulse and op toggle mid-run are ignored
      uut_op = 2'b10;
      run_and_check(0, 2'b10, 60);

      // Back-to-back restart straight from DONE
      run_and_check(0, 2'b10, -1);

      // Narrow counter saturates with an inverted UUT
      uut_op = 2'b11;
      invert = 1'b1;
      run_and_check(2, 2'b11, -1);
      chk("sat_err_15", err2, 15);
      invert = 1'b0;

      // Randomized ops, faults and mid-run noise across all instances
      for (int r = 0; r < 9; r++) begin
         int         d, pct;
         logic [1:0] o;
         d       = r % 3;
         o       = 2'($urandom_range(0, 3));
         uut_op  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : o;
         pct     = int'($urandom_range(0, 3));
         invert  = (d == 2) && ($urandom_range(0, 1) == 1);
         uut_lat = lat_of(d);
         for (int k = 0; k < 256; k++)
            fault_mask[k] = (int'($urandom_range(0, 99)) < pct) ? 4'($urandom_range(1, 15)) : 4'h0;
         run_and_check(d, o, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 250)) : -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_logic_bist.md
# alu_logic_bist

Built-in self-test sequencer for the four-bit ALU's bitwise logic units (AND/OR/XOR/XNOR). On `start` it drives every operand pair (a, b) into the unit under test (UUT) and checks each returned `y` against the selected operation. It counts mismatches, captures the first failing vector and reports pass/fail. It sits beside the ALU logic slice and lets the same vector checks run on silicon/FPGA without a simulator.

## Interface
Parameters:
- `WIDTH`, 4, operand width; vector space is 2^(2*WIDTH) pairs.
- `LAT`, 0, UUT latency in clock cycles, from `a`/`b` change to valid `y`; legal range 0..3.
- `ERR_W`, 8, width of the error counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled in IDLE or DONE only.
- `op`  in  2  operation under test: 00 AND, 01 OR, 10 XOR, 11 XNOR; latched on accepted `start`.
- `a`  out  WIDTH  operand A to UUT, registered.
- `b`  out  WIDTH  operand B to UUT, registered.
- `y`  in  WIDTH  UUT result.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE (level).
- `pass`  out  1  valid while `done`; 1 when `err_count` == 0.
- `err_count`  out  ERR_W  mismatches in the current or last run; saturates at all-ones.
- `first_err_a`, `first_err_b`  out  WIDTH  operands of the first mismatch; 0 if none.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE with `start`=1 → RUN. This edge loads vector counter `cnt` to 0, clears `err_count`, `first_err_*` and the first-error flag, and latches `op`.
  - RUN: `{a,b}` = `cnt` (a = upper WIDTH bits). `cnt` increments each cycle. After the edge that presents the all-ones vector, go to DRAIN if `LAT`>0, otherwise DONE, after the final compare (see Timing).
  - DRAIN: `a`/`b` hold the all-ones vector for the remaining compare cycles. Then go to DONE.
  - DONE: `done`=1. `a`/`b` = 0. Stay until `start` or `rst`.
- Expected value: op(a_d, b_d). a_d/b_d are the operands delayed by `LAT` cycles through the delay line, so each `y` is compared with the vector that produced it.
- A mismatch means any bit differs, using 4-state inequality in simulation. Each mismatch increments `err_count` unless the counter is all-ones. The first mismatch of a run loads `first_err_a`/`first_err_b`.
- `start` while `busy` is ignored. `op` changes mid-run are ignored.
- Reset values of all outputs: `a`, `b`, `busy`, `done`, `pass`, `err_count`, `first_err_*` = 0. State = IDLE.
- `rst` asserted mid-run aborts immediately to the reset values. No partial result is retained.

## Timing
- Reference edge t0 is the edge sampling an accepted `start`.
- Vector k (0..2^(2W)-1) is on `a`/`b` after edge t0+k.
- The compare for vector k is registered at edge t0+k+1+LAT.
- The final compare is at edge t0+2^(2W)+LAT.
- `done`, `pass` and final `err_count` are all visible after edge t0+2^(2W)+1+LAT. For WIDTH=4, LAT=0 that is 257 cycles after start.
- `busy` rises at t0. It falls on the same edge `done` rises.
- Back-to-back: `start` held high in DONE restarts on the next edge. `done` drops at that edge.

## Structure
- Shared package `alu_pkg` holds:
  - the op encoding constants (OP_AND, OP_OR, OP_XOR, OP_XNOR);
  - a function `alu_logic_eval(op, a, b)` returning the expected result, reused by the testbenches.
- Sub-module `alu_bist_delay`: a `LAT`-stage register pipe for {a,b}. It is a pass-through when `LAT`=0 and is reset asynchronously to 0.
- The FSM, counter and error capture stay in `alu_logic_bist`.

## Test plan
- Correct combinational XNOR UUT, WIDTH=4, LAT=0, op=11, pulse `start` → `done` rises 257 cycles after start, `pass`=1, `err_count`=0, `first_err_*`=0.
- UUT bit0 stuck-at-0, op=11 → `err_count`=128, `pass`=0, `first_err_a`=0000, `first_err_b`=0000.
- Registered AND UUT, LAT=2, op=00 → `done` at 259 cycles, `pass`=1. Same UUT with LAT=0 programmed → `pass`=0, nonzero `err_count`.
- Assert `rst` when `a`=0110, `b`=0100 (vector 100) → all outputs 0 next sample and state IDLE. A following `start` runs a full 257-cycle pass.
- Pulse `start` and toggle `op` mid-run → ignored, the run completes with the originally latched op, and `done` timing is unchanged.
- ERR_W=4, UUT output inverted → `err_count`=1111 (saturated), `pass`=0, `first_err_*`=0000/0000.
